// File: rtl/mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) arbiter for a single memory channel.
// One transaction in flight, round-robin on ties, watchdog completes hung responses with an error.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   // IFU port
   input  logic              ifu_req,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_gnt,
   output logic              ifu_rvalid,
   output logic [DATA_W-1:0] ifu_rdata,
   output logic              ifu_err,
   // LSU port
   input  logic              lsu_req,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic              lsu_wen,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [7:0]        lsu_wmask,
   output logic              lsu_gnt,
   output logic              lsu_rvalid,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              lsu_err,
   // memory port
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [7:0]        mem_wmask,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   // FSM state for observation
   output logic [1:0]        o_dbg_state
);

   // Handshakes: a master holds req and its fields until its gnt pulse; mem_req and mem_*
   // are held until mem_ready; a response is a single-cycle rvalid pulse to the owner.

   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam bit WDOG_EN = (TIMEOUT != 0);

   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_owner;
   logic              r_last_owner;
   logic [ADDR_W-1:0] r_addr;
   logic              r_wen;
   logic [DATA_W-1:0] r_wdata;
   logic [7:0]        r_wmask;
   logic [CNT_W-1:0]  r_cnt;

   state_t            w_next_state;
   logic              w_sel_lsu;
   logic              w_grant;
   logic              w_resp_valid;
   logic              w_resp_err;
   logic [DATA_W-1:0] w_resp_data;
   logic [CNT_W-1:0]  w_cnt_next;

   always_comb begin
      w_next_state = r_state;
      w_sel_lsu    = 1'b0;
      w_grant      = 1'b0;
      w_resp_valid = 1'b0;
      w_resp_err   = 1'b0;
      w_resp_data  = '0;
      w_cnt_next   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            // On a tie the master that did not win last time goes first.
            if (ifu_req && lsu_req) w_sel_lsu = (r_last_owner == OWN_IFU);
            else                    w_sel_lsu = lsu_req;
            if (ifu_req || lsu_req) begin
               w_grant      = 1'b1;
               w_next_state = ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_ready) begin
               w_next_state = ST_RESP;
               w_cnt_next   = '0;
            end
         end
         ST_RESP: begin
            // A real response wins over a watchdog expiry in the same cycle.
            if (mem_rvalid) begin
               w_resp_valid = 1'b1;
               w_resp_data  = mem_rdata;
               w_next_state = ST_IDLE;
            end else if (WDOG_EN && (r_cnt == CNT_LAST)) begin
               w_resp_valid = 1'b1;
               w_resp_err   = 1'b1;
               w_next_state = ST_IDLE;
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_owner      <= OWN_IFU;
         r_last_owner <= OWN_LSU;
         r_addr       <= '0;
         r_wen        <= 1'b0;
         r_wdata      <= '0;
         r_wmask      <= '0;
         r_cnt        <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_cnt_next;
         if (w_grant) begin
            r_owner      <= w_sel_lsu;
            r_last_owner <= w_sel_lsu;
            r_addr       <= w_sel_lsu ? lsu_addr : ifu_addr;
            r_wen        <= w_sel_lsu & lsu_wen;
            r_wdata      <= w_sel_lsu ? lsu_wdata : '0;
            r_wmask      <= w_sel_lsu ? lsu_wmask : 8'h00;
         end
      end
   end

   // Outputs are forced low while reset is asserted, including the combinational grant.
   assign ifu_gnt    = rst & w_grant & ~w_sel_lsu;
   assign lsu_gnt    = rst & w_grant & w_sel_lsu;

   assign ifu_rvalid = rst & w_resp_valid & (r_owner == OWN_IFU);
   assign ifu_rdata  = ifu_rvalid ? w_resp_data : '0;
   assign ifu_err    = ifu_rvalid & w_resp_err;

   assign lsu_rvalid = rst & w_resp_valid & (r_owner == OWN_LSU);
   assign lsu_rdata  = lsu_rvalid ? w_resp_data : '0;
   assign lsu_err    = lsu_rvalid & w_resp_err;

   assign mem_req    = rst & (r_state == ST_REQ);
   assign mem_addr   = mem_req ? r_addr : '0;
   assign mem_wen    = mem_req & r_wen;
   assign mem_wdata  = mem_req ? r_wdata : '0;
   assign mem_wmask  = mem_req ? r_wmask : 8'h00;

   assign o_dbg_state = r_state;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, single-port memory arbiter that shares one memory request/response channel between the IFU (read-only) and the LSU (read/write).
- Sits between the IFU/LSU and the memory model/bus; one transaction outstanding at a time; round-robin fairness.
- Includes a response watchdog that terminates hung transactions with an error.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, max cycles waiting in RESP before error completion; 0 disables watchdog

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-low (asserted when 0)
ifu_req  in  1  IFU read request; held with ifu_addr until ifu_gnt
ifu_addr  in  ADDR_W  IFU read address
ifu_gnt  out  1  one-cycle pulse: IFU request accepted
ifu_rvalid  out  1  IFU response valid (one cycle)
ifu_rdata  out  DATA_W  IFU read data; 0 when ifu_rvalid=0
ifu_err  out  1  qualifies ifu_rvalid: watchdog expiry
lsu_req  in  1  LSU request; held with all lsu_* fields until lsu_gnt
lsu_addr  in  ADDR_W  LSU address
lsu_wen  in  1  1=write, 0=read
lsu_wdata  in  DATA_W  write data
lsu_wmask  in  8  byte write mask
lsu_gnt  out  1  one-cycle pulse: LSU request accepted
lsu_rvalid  out  1  LSU response valid; also acknowledges writes
lsu_rdata  out  DATA_W  LSU read data; 0 when lsu_rvalid=0
lsu_err  out  1  qualifies lsu_rvalid: watchdog expiry
mem_req  out  1  request to memory, held until mem_ready
mem_addr  out  ADDR_W  latched address
mem_wen  out  1  latched write enable (0 for IFU)
mem_wdata  out  DATA_W  latched write data (0 for IFU)
mem_wmask  out  8  latched mask (0 for IFU)
mem_ready  in  1  memory accepts the request this cycle
mem_rvalid  in  1  memory response/write-ack valid
mem_rdata  in  DATA_W  memory read data

Behaviour:
- FSM states: IDLE, REQ, RESP. Registers: state, owner (IFU/LSU), last_owner, latched request fields, watchdog counter.
- Reset (rst==0 at posedge): state=IDLE, last_owner=LSU, counter=0, latched fields=0. All outputs 0. Reset mid-transaction abandons it; a later mem_rvalid is ignored because state is IDLE.
- IDLE:
  - Requesters present: only one -> pick it. Both -> pick the one != last_owner (after reset, IFU wins the first tie).
  - The chosen master's gnt=1 combinationally this cycle. Fields latched, owner set, last_owner set to the chosen master, next state REQ.
  - No request -> stay in IDLE.
- REQ:
  - mem_req=1 and mem_* driven from latched registers.
  - mem_ready=1 -> RESP, counter=0. Otherwise hold.
  - mem_rvalid is ignored in REQ; memory responds no earlier than the cycle after accept.
  - Watchdog does not run in REQ.
- RESP:
  - mem_req=0.
  - mem_rvalid=1 -> owner's rvalid=1 and owner's rdata=mem_rdata in the same cycle (combinational pass-through), err=0, next state IDLE.
  - Otherwise counter increments. With TIMEOUT!=0 and counter==TIMEOUT-1 without mem_rvalid: owner's rvalid=1, err=1, rdata=0, next state IDLE. mem_rvalid in that same cycle takes precedence (normal completion).
- The non-owner's rvalid, rdata and err are always 0. gnt never asserts outside IDLE.
- Best-case latency: gnt at cycle 0, mem_req at cycle 1, mem_ready at cycle 1, earliest rvalid at cycle 2. The next grant is possible in the cycle after rvalid.
- A master that deasserts req before gnt is simply not granted; no state is kept for it.
- Counter width is ceil(log2(TIMEOUT+1)), minimum 1.

Test Plan:
- Reset: rst=0 for 2 cycles with ifu_req=1 -> all outputs 0. Release -> ifu_gnt at first IDLE cycle, mem_req=1 and mem_addr=ifu_addr next cycle.
- Single IFU read at 0x80000000, mem_ready same cycle, mem_rvalid 3 cycles later with 0x00000413 -> ifu_rvalid pulse with ifu_rdata=0x00000413, lsu_rvalid=0.
- LSU write, addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F -> mem_wen=1 and mem_wmask=0x0F held through mem_ready=0 for 4 cycles. On ack -> lsu_rvalid=1, lsu_err=0.
- Both requesting continuously, 4 transactions -> grant order IFU, LSU, IFU, LSU; mem_wen=0 on every IFU transaction.
- TIMEOUT=8, mem_ready=1, mem_rvalid never -> exactly 8 RESP cycles, then ifu_rvalid=1, ifu_err=1, ifu_rdata=0, state IDLE. mem_rvalid arriving later is ignored.
- Reset asserted in RESP, then mem_rvalid=1 one cycle after release -> no rvalid on either master; the next tie goes to IFU.
